// File: rtl/dpram_rd_stream_pkg.sv
// dpram_rd_stream_pkg
// Shared types and constants for the DMA staging-RAM read stream engine:
//   - state_e     : engine FSM states (IDLE, RUN, DRAIN)
//   - ADDR_W_DEF  : default RAM address width (32-word RAM)
//   - DATA_W_DEF  : default word width
//   - FIFO_DEPTH  : output FIFO entries (also the read credit limit)
//   - CNT_W       : width of the FIFO occupancy count
package dpram_rd_stream_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/dpram_rd_stream_if.sv
// dpram_rd_stream_if
// Valid/ready word stream toward the systolic-array feeder.
//   m_valid : word valid            (master -> slave)
//   m_ready : downstream accept     (slave  -> master)
//   m_data  : stream word           (master -> slave)
//   m_last  : final word of command (master -> slave)
interface dpram_rd_stream_if #(
  parameter int DATA_W = 32
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/dpram_rd_stream_fifo.sv
// stream_fifo2
// Two-entry FIFO of {last, data}. The head entry is a register that drives
// the outputs directly, so out_data/out_last are stable while out_valid is
// high and no pop occurs. The caller guarantees no push into a full FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_last/push_data this cycle
//   pop        : consume the head entry (ignored when empty)
//   count      : current occupancy 0..2
//   out_valid  : head entry present
//   out_last   : head entry last flag
//   out_data   : head entry word
module stream_fifo2
  import dpram_rd_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_last,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] CNT_0 = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_2 = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q;
  logic              head_last_q;
  logic [DATA_W-1:0] head_data_q;
  logic              tail_last_q;
  logic [DATA_W-1:0] tail_data_q;
  logic              pop_eff;
  logic              tail_wr;

  assign pop_eff = pop && (cnt_q != CNT_0);

  // Tail is written when a push lands behind a head that stays occupied.
  assign tail_wr = push && (((cnt_q == CNT_1) && !pop_eff) || ((cnt_q == CNT_2) && pop_eff));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= CNT_0;
      head_last_q <= 1'b0;
      head_data_q <= '0;
    end else begin
      case (cnt_q)
        CNT_0: begin
          if (push) begin
            head_last_q <= push_last;
            head_data_q <= push_data;
            cnt_q       <= CNT_1;
          end
        end
        CNT_1: begin
          if (push && pop_eff) begin
            head_last_q <= push_last;
            head_data_q <= push_data;
          end else if (push) begin
            cnt_q <= CNT_2;
          end else if (pop_eff) begin
            cnt_q <= CNT_0;
          end
        end
        CNT_2: begin
          if (pop_eff) begin
            head_last_q <= tail_last_q;
            head_data_q <= tail_data_q;
            if (!push) cnt_q <= CNT_1;
          end
        end
        default: cnt_q <= CNT_0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tail_wr) begin
      tail_last_q <= push_last;
      tail_data_q <= push_data;
    end
  end

  assign count     = cnt_q;
  assign out_valid = (cnt_q != CNT_0);
  assign out_last  = head_last_q;
  assign out_data  = head_data_q;

endmodule

// File: rtl/dpram_rd_stream.sv
// dpram_rd_stream
// Read-side stream engine for the DMA staging RAM. A start command reads a
// run of len words from base_addr (advancing by stride, or by 1) through the
// RAM's registered read port and streams them out in order with m_last on
// the final word. Reads are issued only when a FIFO slot is guaranteed, so
// FIFO plus in-flight read never exceed two words under backpressure.
// Optional feature macro: DPRAM_RD_STREAM_STRIDE_EN (adds the stride port).
//   clk, rst   : clock, synchronous active-high reset
//   start      : command strobe, sampled only in IDLE
//   base_addr  : first read address
//   len        : word count 0..2^ADDR_W
//   stride     : address increment (only with DPRAM_RD_STREAM_STRIDE_EN)
//   busy       : command in progress
//   done       : one-cycle completion pulse
//   mem_ren    : RAM read enable
//   mem_raddr  : RAM read address
//   mem_rdata  : RAM read data, valid the cycle after mem_ren
//   m          : output stream (m_valid/m_ready/m_data/m_last)
module dpram_rd_stream
  import dpram_rd_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
`ifdef DPRAM_RD_STREAM_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  dpram_rd_stream_if.master m
);

  localparam logic [CNT_W:0]   FIFO_CAP = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_0    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_1    = CNT_W'(1);

  state_e            state_q, state_d;
  logic              busy_q, done_q;
  logic [ADDR_W:0]   len_q, issued_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] step_q;
  logic              vld_p1, last_p1;
  logic              accept, zero_cmd, finish, issue, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ;
  logic              fifo_valid, fifo_last;
  logic [DATA_W-1:0] fifo_data;

  assign pop = fifo_valid && m.m_ready;

  // Words already committed to the FIFO after this cycle's pop: buffered
  // entries plus the read whose data lands next edge.
  assign occ = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1} - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    accept   = 1'b0;
    zero_cmd = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            zero_cmd = 1'b1;
          end
        end
      end
      RUN: begin
        issue = (issued_q < len_q) && (occ < FIFO_CAP);
        if (issue && ((issued_q + 1'b1) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!vld_p1 && ((fifo_count == CNT_0) || ((fifo_count == CNT_1) && pop))) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: issue read, advance address and issue count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
      raddr_q  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= zero_cmd | finish;
      vld_p1  <= issue;
      if (accept)      busy_q <= 1'b1;
      else if (finish) busy_q <= 1'b0;
      if (accept) begin
        issued_q <= '0;
        raddr_q  <= base_addr;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
        raddr_q  <= raddr_q + step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) len_q <= len;
    if (issue)  last_p1 <= ((issued_q + 1'b1) == len_q);
  end

`ifdef DPRAM_RD_STREAM_STRIDE_EN
  always_ff @(posedge clk) begin
    if (accept) step_q <= stride;
  end
`else
  assign step_q = ADDR_W'(1);
`endif

  // Stage p1: RAM data returns, tagged with its last flag, into the FIFO
  stream_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_last (last_p1),
    .push_data (mem_rdata),
    .pop       (pop),
    .count     (fifo_count),
    .out_valid (fifo_valid),
    .out_last  (fifo_last),
    .out_data  (fifo_data)
  );

  assign mem_ren   = issue;
  assign mem_raddr = raddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m.m_valid = fifo_valid;
  assign m.m_last  = fifo_last;
  assign m.m_data  = fifo_data;

endmodule

// File: tb/tb_dpram_rd_stream.sv
`timescale 1ns/1ps
module tb_dpram_rd_stream;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
`ifdef DPRAM_RD_STREAM_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;

  dpram_rd_stream_if #(.DATA_W(DW)) sif ();

  dpram_rd_stream #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef DPRAM_RD_STREAM_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .m         (sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with one-cycle registered read
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA000_0000 + i;
  always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_raddr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected (got 1, expected 0) at cycle %0d", name, cyc);
  endtask

  // Scoreboard state
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            mon_en = 0;
  bit            cmd_active = 0;
  int            cmd_len, start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int            issued_cnt, popped_cnt;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Ready driver: 0 = always ready, 1 = random, 2 = stall window
  int rdy_mode = 0;
  int stall_lo = 1000000000;
  int stall_hi = 1000000000;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       sif.m_ready = ($urandom_range(0, 3) != 0);
      2:       sif.m_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
      default: sif.m_ready = 1'b1;
    endcase
  end

  // Monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    bit pop_now;
    if (mon_en && !rst) begin
      pop_now = sif.m_valid && sif.m_ready;
      if (prev_stall) begin
        chk("hold_valid", sif.m_valid, 1);
        chk("hold_data", sif.m_data, prev_data);
        chk("hold_last", sif.m_last, prev_last);
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_data  = sif.m_data;
      prev_last  = sif.m_last;
      if (sif.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mem_ren) begin
        if (addr_q.size() == 0) flag("extra_read");
        else chk("raddr", mem_raddr, addr_q.pop_front());
        chk("credit", ((issued_cnt - popped_cnt - (pop_now ? 1 : 0)) < 2), 1);
        issued_cnt++;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) flag("extra_word");
        else begin
          e = exp_q.pop_front();
          chk("data", sif.m_data, e[DW-1:0]);
          chk("last", sif.m_last, e[DW]);
        end
        popped_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        if (!cmd_active) flag("spurious_done");
        else begin
          if (cmd_len == 0) chk("done_cyc_len0", cyc, start_cyc + 1);
          else chk("done_after_last", cyc, last_hs_cyc + 1);
          chk("busy_at_done", busy, 0);
          chk("words_left", exp_q.size(), 0);
          chk("reads_left", addr_q.size(), 0);
          done_cyc = cyc;
          cmd_active = 0;
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  // Issue one command and push its expected reads and words
  task automatic run_cmd(input int b, input int l, input int s, output int sc);
    int step;
    int a;
`ifdef DPRAM_RD_STREAM_STRIDE_EN
    step = s;
`else
    step = 1;
`endif
    $display("cmd base=%0d len=%0d stride=%0d", b, l, s);
    @(posedge clk);
    #1;
    base_addr = AW'(b);
    len       = (AW + 1)'(l);
`ifdef DPRAM_RD_STREAM_STRIDE_EN
    stride    = AW'(s);
`endif
    start     = 1'b1;
    sc = cyc;
    cmd_active = 1; cmd_len = l; start_cyc = cyc;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    issued_cnt = 0; popped_cnt = 0;
    for (int i = 0; i < l; i++) begin
      a = (b + i * step) % DEPTH;
      addr_q.push_back(AW'(a));
      exp_q.push_back({(i == l - 1), ram[a]});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (cmd_active && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (cmd_active) begin
      flag("done_timeout");
      cmd_active = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int b, l, s;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
`ifdef DPRAM_RD_STREAM_STRIDE_EN
    stride = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_raddr", mem_raddr, 0);
    chk("rst_m_valid", sif.m_valid, 0);
    chk("rst_m_data", sif.m_data, 0);
    chk("rst_m_last", sif.m_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    // Basic run, ready high: latency and throughput
    rdy_mode = 0;
    run_cmd(0, 4, 1, sc);
    wait_done(100);
    chk("first_valid_cyc", first_valid_cyc, sc + 3);
    chk("last_hs_cyc", last_hs_cyc, sc + 6);
    chk("done_cyc", done_cyc, sc + 7);

    // Address wrap
    run_cmd(30, 4, 1, sc);
    wait_done(100);

    // Zero-length command
    run_cmd(7, 0, 1, sc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_busy", busy, 0);
      chk("len0_mem_ren", mem_ren, 0);
      chk("len0_m_valid", sif.m_valid, 0);
    end
    wait_done(10);

    // Backpressure window
    rdy_mode = 2;
    run_cmd(0, 8, 1, sc);
    stall_lo = sc + 4;
    stall_hi = sc + 9;
    wait_done(200);
    chk("stall_words", popped_cnt, 8);
    rdy_mode = 0;
    stall_lo = 1000000000;
    stall_hi = 1000000000;

    // Reset mid-transfer
    run_cmd(0, 8, 1, sc);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mem_ren", mem_ren, 0);
    chk("mid_rst_mem_raddr", mem_raddr, 0);
    chk("mid_rst_m_valid", sif.m_valid, 0);
    chk("mid_rst_m_data", sif.m_data, 0);
    chk("mid_rst_m_last", sif.m_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    cmd_active = 0;
    mon_en = 1;
    run_cmd(2, 1, 1, sc);
    wait_done(100);
    chk("after_rst_words", popped_cnt, 1);

    // Strided command (stride ignored without the feature)
    run_cmd(5, 3, 3, sc);
    wait_done(100);

    // Randomized commands with random backpressure and ignored starts
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH);
      s = $urandom_range(0, DEPTH - 1);
      run_cmd(b, l, s, sc);
      if (l > 0 && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        len = (AW + 1)'(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done(400);
      chk("rand_words", popped_cnt, l);
    end
    rdy_mode = 0;

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_rd_stream.md
# dpram_rd_stream

Read-side stream engine for the 32-word DMA staging RAM: on a start command it reads a contiguous (optionally strided) run of words from the dual-port RAM read port. It absorbs the RAM's one-cycle registered read latency and presents the words in order on a valid/ready stream toward the systolic-array feeder. A 2-entry output FIFO with credit-based issue guarantees no word is lost or duplicated under arbitrary backpressure.

## Interface
- ADDR_W, 5, RAM address width (depth 2^ADDR_W)
- DATA_W, 32, word width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first read address
- len  in  ADDR_W+1  word count, 0..32
- stride  in  ADDR_W  address increment (present only with DPRAM_RD_STREAM_STRIDE_EN)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- mem_ren  out  1  RAM read enable
- mem_raddr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_ren
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  stream word
- m_last  out  1  marks the final word of the command

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start && len!=0: latch base, len, and stride; clear the issue counter; go to RUN; busy=1.
  - start && len==0: done pulses next cycle; stay in IDLE; no reads are issued.
- RUN: issue a read when issued<len and (fifo_count + inflight − pop) < 2, where pop = m_valid && m_ready.
  - mem_ren is combinational from registered state; mem_raddr is a register.
  - After each issue: addr ← (addr + stride) mod 2^ADDR_W, so wrap 31→0 is natural. Stride is 1 when the macro is absent.
  - When issued==len, go to DRAIN.
- inflight: 1-bit register set by mem_ren. The following cycle, mem_rdata is pushed into the FIFO with a last flag, which is set when it is word len−1.
- DRAIN: when the FIFO is empty and inflight==0, pulse done, clear busy, go to IDLE.
- start is ignored while busy.
- m_data and m_last are held stable while m_valid && !m_ready.
- rst in any state: FSM→IDLE, FIFO flushed, inflight read discarded, counters cleared.
- Reset values: busy=0, done=0, mem_ren=0, mem_raddr=0, m_valid=0, m_data=0, m_last=0.

## Timing
- start accepted in cycle 0 → first mem_ren in cycle 1 → word in FIFO at end of cycle 2 → m_valid in cycle 3.
- Latency from start to first m_valid: 3 cycles.
- Throughput: 1 word/cycle with m_ready held high.
- done is asserted the cycle after the m_last handshake; busy falls in that same cycle.
- A new start is accepted in the cycle done is high (state is IDLE).
- Backpressure: at most 2 words are buffered (FIFO plus inflight), then mem_ren drops until a pop occurs.

## Configuration
- DPRAM_RD_STREAM_STRIDE_EN defined: the stride port exists and the address advances by the latched stride; stride 0 re-reads the same word len times.
- Undefined: no stride port; the increment is fixed at 1.

## Structure
- Package dpram_rd_stream_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - default ADDR_W/DATA_W constants;
  - FIFO_DEPTH=2 and the count width.
- Sub-module stream_fifo2 is a 2-entry FIFO of {last, data} with push, pop, count, and registered outputs. The top level holds the FSM, address/issue counters, and credit logic.

## Test plan
Preload ram[i]=0xA0000000+i.
- base=0, len=4, m_ready=1, start at cycle 0 → m_valid cycles 3–6 with data A0000000..A0000003, m_last in cycle 6, done in cycle 7.
- base=30, len=4 → mem_raddr sequence 30,31,0,1; data A000001E, A000001F, A0000000, A0000001.
- len=0 → done in cycle 1, busy stays 0, mem_ren never asserted, m_valid never asserted.
- base=0, len=8, m_ready low cycles 4–9 → m_data stable during the stall, mem_ren low after 2 buffered words, all 8 words delivered in order exactly once.
- rst high in cycle 4 of a len=8 transfer → all outputs 0 in cycle 5; next start with base=2, len=1 delivers A0000002 with m_last set.
- With DPRAM_RD_STREAM_STRIDE_EN: base=5, stride=3, len=3 → addresses 5,8,11. Without the macro, the same command reads 5,6,7.
